// File: rtl/ex_stage_pkg.sv
// Shared widths, opcodes and op-class codes for the MIPS32 execute stage.
package ex_stage_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned RegAddrBus   = 5;
    localparam int unsigned AluOpBus     = 8;
    localparam int unsigned AluOpTypeBus = 3;

    typedef enum logic [AluOpTypeBus-1:0] {
        OpTypeNop   = 3'd0,
        OpTypeLogic = 3'd1,
        OpTypeShift = 3'd2,
        OpTypeArith = 3'd3,
        OpTypeMove  = 3'd4,
        OpTypeMul   = 3'd5,
        OpTypeDiv   = 3'd6
    } op_type_e;

    typedef enum logic [AluOpBus-1:0] {
        AluNop   = 8'h00,
        AluSrl   = 8'h02,
        AluSra   = 8'h03,
        AluMfhi  = 8'h10,
        AluMthi  = 8'h11,
        AluMflo  = 8'h12,
        AluMtlo  = 8'h13,
        AluMult  = 8'h18,
        AluMultu = 8'h19,
        AluDiv   = 8'h1a,
        AluDivu  = 8'h1b,
        AluAdd   = 8'h20,
        AluAddu  = 8'h21,
        AluSub   = 8'h22,
        AluSubu  = 8'h23,
        AluAnd   = 8'h24,
        AluOr    = 8'h25,
        AluXor   = 8'h26,
        AluNor   = 8'h27,
        AluSlt   = 8'h2a,
        AluSltu  = 8'h2b,
        AluSll   = 8'h7c
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX input bundle and EX/MEM output bundle of the execute stage.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic [AluOpBus-1:0]     aluop_i;
    logic [AluOpTypeBus-1:0] aluoptype_i;
    logic [RegBus-1:0]       reg1_data_i;
    logic [RegBus-1:0]       reg2_data_i;
    logic                    wreg_i;
    logic [RegAddrBus-1:0]   rd_addr_i;
    logic [RegBus-1:0]       hi_i;
    logic [RegBus-1:0]       lo_i;
    logic                    annul_i;
    logic [RegAddrBus-1:0]   rd_addr_o;
    logic                    wreg_o;
    logic [RegBus-1:0]       wdata_o;
    logic                    whilo_o;
    logic [RegBus-1:0]       hi_o;
    logic [RegBus-1:0]       lo_o;
    logic                    stallreq_o;

    modport master (
        output aluop_i, aluoptype_i, reg1_data_i, reg2_data_i, wreg_i, rd_addr_i,
               hi_i, lo_i, annul_i,
        input  rd_addr_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, aluoptype_i, reg1_data_i, reg2_data_i, wreg_i, rd_addr_i,
               hi_i, lo_i, annul_i,
        output rd_addr_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

endinterface

// File: rtl/ex_stage_div_unit.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes, signs fixed up in DONE.
module ex_stage_div_unit
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        annul_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    div_state_e  state_q, state_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [32:0] partial;
    logic        fits;
    logic [31:0] opa_abs, opb_abs;

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_i) state_d = (opb_i == 32'd0) ? StDone : StBusy;
            StBusy: begin
                if (annul_i)              state_d = StIdle;
                else if (cnt_q == 5'd31)  state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o      = (state_q == StBusy);
        done_o      = (state_q == StDone);
        quotient_o  = neg_quo_q ? -quo_q : quo_q;
        remainder_o = neg_rem_q ? -rem_q : rem_q;
    end

    // Shift the next dividend bit into the 33-bit partial remainder, subtract if it fits.
    assign partial = {rem_q, quo_q[31]};
    assign fits    = partial >= {1'b0, dvs_q};
    assign opa_abs = (signed_i && opa_i[31]) ? -opa_i : opa_i;
    assign opb_abs = (signed_i && opb_i[31]) ? -opb_i : opb_i;

    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (state_q == StIdle && start_i) begin
            cnt_d = 5'd0;
            rem_d = 32'd0;
            if (opb_i == 32'd0) begin
                quo_d     = 32'd0;
                dvs_d     = 32'd0;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
            end else begin
                quo_d     = opa_abs;
                dvs_d     = opb_abs;
                neg_quo_d = signed_i && (opa_i[31] ^ opb_i[31]);
                neg_rem_d = signed_i && opa_i[31];
            end
        end else if (state_q == StBusy) begin
            quo_d = {quo_q[30:0], fits};
            rem_d = fits ? (partial[31:0] - dvs_q) : partial[31:0];
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dvs_q     <= 32'd0;
            cnt_q     <= 5'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: combinational ALU, HI/LO write-back and stall control for the divider.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    ex_stage_if.slave ex_if
);

    logic [31:0] a, b, sum, dif, div_quo, div_rem;
    logic [63:0] prod_s, prod_u;
    logic        ovf_add, ovf_sub;
    logic        div_op, div_busy, div_done, div_idle;

    assign a       = ex_if.reg1_data_i;
    assign b       = ex_if.reg2_data_i;
    assign sum     = a + b;
    assign dif     = a - b;
    assign ovf_add = (a[31] == b[31]) && (sum[31] != a[31]);
    assign ovf_sub = (a[31] != b[31]) && (dif[31] != a[31]);
    assign prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u  = {32'd0, a} * {32'd0, b};
    assign div_op  = (ex_if.aluoptype_i == OpTypeDiv);
    assign div_idle = !div_busy && !div_done;

    ex_stage_div_unit u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_op && !ex_if.annul_i),
        .signed_i    (ex_if.aluop_i == AluDiv),
        .annul_i     (ex_if.annul_i),
        .opa_i       (a),
        .opb_i       (b),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_comb begin
        ex_if.rd_addr_o  = ex_if.rd_addr_i;
        ex_if.wreg_o     = ex_if.wreg_i;
        ex_if.wdata_o    = 32'd0;
        ex_if.whilo_o    = 1'b0;
        ex_if.hi_o       = 32'd0;
        ex_if.lo_o       = 32'd0;
        ex_if.stallreq_o = (div_idle && div_op && !ex_if.annul_i) || div_busy;
        case (ex_if.aluop_i)
            AluAnd:  ex_if.wdata_o = a & b;
            AluOr:   ex_if.wdata_o = a | b;
            AluXor:  ex_if.wdata_o = a ^ b;
            AluNor:  ex_if.wdata_o = ~(a | b);
            AluSll:  ex_if.wdata_o = b << a[4:0];
            AluSrl:  ex_if.wdata_o = b >> a[4:0];
            AluSra:  ex_if.wdata_o = $signed(b) >>> a[4:0];
            AluAdd: begin
                ex_if.wdata_o = sum;
                if (ovf_add) ex_if.wreg_o = 1'b0;
            end
            AluAddu: ex_if.wdata_o = sum;
            AluSub: begin
                ex_if.wdata_o = dif;
                if (ovf_sub) ex_if.wreg_o = 1'b0;
            end
            AluSubu: ex_if.wdata_o = dif;
            AluSlt:  ex_if.wdata_o = {31'd0, $signed(a) < $signed(b)};
            AluSltu: ex_if.wdata_o = {31'd0, a < b};
            AluMfhi: ex_if.wdata_o = ex_if.hi_i;
            AluMflo: ex_if.wdata_o = ex_if.lo_i;
            AluMthi: begin
                ex_if.whilo_o = 1'b1;
                ex_if.hi_o    = a;
                ex_if.lo_o    = ex_if.lo_i;
            end
            AluMtlo: begin
                ex_if.whilo_o = 1'b1;
                ex_if.hi_o    = ex_if.hi_i;
                ex_if.lo_o    = a;
            end
            AluMult: begin
                ex_if.whilo_o = 1'b1;
                {ex_if.hi_o, ex_if.lo_o} = prod_s;
            end
            AluMultu: begin
                ex_if.whilo_o = 1'b1;
                {ex_if.hi_o, ex_if.lo_o} = prod_u;
            end
            default: ;
        endcase
        // Op class gates the ALU result so an opcode under the wrong class writes nothing.
        unique case (ex_if.aluoptype_i)
            OpTypeLogic, OpTypeShift, OpTypeArith: begin
                ex_if.whilo_o = 1'b0;
                ex_if.hi_o    = 32'd0;
                ex_if.lo_o    = 32'd0;
            end
            OpTypeMove: ;
            OpTypeMul: begin
                ex_if.wreg_o  = 1'b0;
                ex_if.wdata_o = 32'd0;
            end
            OpTypeDiv: begin
                ex_if.wreg_o  = 1'b0;
                ex_if.wdata_o = 32'd0;
                ex_if.whilo_o = div_done;
                ex_if.hi_o    = div_done ? div_rem : 32'd0;
                ex_if.lo_o    = div_done ? div_quo : 32'd0;
            end
            default: begin
                ex_if.wdata_o = 32'd0;
                ex_if.whilo_o = 1'b0;
                ex_if.hi_o    = 32'd0;
                ex_if.lo_o    = 32'd0;
            end
        endcase
        if (rst) begin
            ex_if.rd_addr_o  = '0;
            ex_if.wreg_o     = 1'b0;
            ex_if.wdata_o    = 32'd0;
            ex_if.whilo_o    = 1'b0;
            ex_if.hi_o       = 32'd0;
            ex_if.lo_o       = 32'd0;
            ex_if.stallreq_o = 1'b0;
        end
    end

endmodule
